// File: rtl/sprite_move_ctrl.sv
// Frame-paced movement for one grid sprite: one captured direction per frame,
// fixed-point position clamped to the playfield, per-edge collision blocking.
module sprite_move_ctrl #(
  parameter int FP_SHIFT   = 6,
  parameter int OBJ_W      = 32,
  parameter int OBJ_H      = 32,
  parameter int FRAME_L    = 15,
  parameter int FRAME_R    = 623,
  parameter int FRAME_T    = 48,
  parameter int FRAME_B    = 464,
  parameter int INIT_X     = 15,
  parameter int INIT_Y     = 48,
  parameter int SPEED_LVLS = 4,
  parameter int SPEED_TABLE [SPEED_LVLS] = '{70, 105, 140, 175},
  localparam int LVL_W     = (SPEED_LVLS > 1) ? $clog2(SPEED_LVLS) : 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame_i,
  input  logic                    up_key_i,
  input  logic                    down_key_i,
  input  logic                    left_key_i,
  input  logic                    right_key_i,
  input  logic                    freeze_i,
  input  logic                    respawn_i,
  input  logic                    collision_i,
  input  logic [3:0]              HitEdgeCode_i,
  input  logic [LVL_W-1:0]        speed_level_i,
  output logic signed [10:0]      topLeftX_o,
  output logic signed [10:0]      topLeftY_o,
  output logic [1:0]              facing_o,
  output logic                    moving_o,
  output logic [LVL_W-1:0]        cur_speed_level_o
);

  localparam int POS_W  = 12 + FP_SHIFT;
  localparam int POS_W1 = POS_W + 1;

  localparam logic signed [POS_W:0]   X_MIN   = POS_W1'(FRAME_L << FP_SHIFT);
  localparam logic signed [POS_W:0]   X_MAX   = POS_W1'((FRAME_R - OBJ_W) << FP_SHIFT);
  localparam logic signed [POS_W:0]   Y_MIN   = POS_W1'(FRAME_T << FP_SHIFT);
  localparam logic signed [POS_W:0]   Y_MAX   = POS_W1'((FRAME_B - OBJ_H) << FP_SHIFT);
  localparam logic signed [POS_W-1:0] SPAWN_X = POS_W'(INIT_X << FP_SHIFT);
  localparam logic signed [POS_W-1:0] SPAWN_Y = POS_W'(INIT_Y << FP_SHIFT);
  localparam logic signed [POS_W-1:0] SPEED0  = POS_W'(SPEED_TABLE[0]);

  typedef enum logic [1:0] {IDLE, COLLECT, SOF, APPLY} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t                   state_q, state_d;
  dir_t                     dir_q, dir_d;
  dir_t                     facing_q, facing_d;
  logic                     dirLock_q, dirLock_d;
  logic [3:0]               hit_q, hit_d;
  logic signed [POS_W-1:0]  xPos_q, xPos_d;
  logic signed [POS_W-1:0]  yPos_q, yPos_d;
  logic signed [POS_W-1:0]  velX_q, velX_d;
  logic signed [POS_W-1:0]  velY_q, velY_d;
  logic signed [POS_W-1:0]  speed_q, speed_d;
  logic [LVL_W-1:0]         curLvl_q, curLvl_d;
  logic                     moving_q, moving_d;

  logic signed [POS_W:0]    sumX, sumY;
  logic [LVL_W-1:0]         lvlSat;
  logic                     blocked;

  function automatic logic signed [POS_W-1:0] clampPos(input logic signed [POS_W:0] v,
                                                       input logic signed [POS_W:0] lo,
                                                       input logic signed [POS_W:0] hi);
    logic signed [POS_W:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return POS_W'(r);
  endfunction

  // One guard bit on the sum so a large step can never wrap before the clamp
  assign sumX = {xPos_q[POS_W-1], xPos_q} + {velX_q[POS_W-1], velX_q};
  assign sumY = {yPos_q[POS_W-1], yPos_q} + {velY_q[POS_W-1], velY_q};

  assign lvlSat = (32'(speed_level_i) >= SPEED_LVLS) ? LVL_W'(SPEED_LVLS - 1) : speed_level_i;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    facing_d  = facing_q;
    dirLock_d = dirLock_q;
    hit_d     = hit_q;
    xPos_d    = xPos_q;
    yPos_d    = yPos_q;
    velX_d    = velX_q;
    velY_d    = velY_q;
    speed_d   = speed_q;
    curLvl_d  = curLvl_q;
    moving_d  = moving_q;
    blocked   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (startOfFrame_i) state_d = COLLECT;
      end
      COLLECT: begin
        if (!freeze_i && !dirLock_q &&
            (up_key_i || down_key_i || left_key_i || right_key_i)) begin
          if (up_key_i)        dir_d = DIR_UP;
          else if (down_key_i) dir_d = DIR_DOWN;
          else if (left_key_i) dir_d = DIR_LEFT;
          else                 dir_d = DIR_RIGHT;
          dirLock_d = 1'b1;
        end
        if (collision_i) hit_d = hit_q | HitEdgeCode_i;
        if (startOfFrame_i) state_d = SOF;
      end
      SOF: begin
        velX_d = '0;
        velY_d = '0;
        if (dirLock_q) begin
          facing_d = dir_q;
          unique case (dir_q)
            DIR_UP:    blocked = hit_q[3];
            DIR_DOWN:  blocked = hit_q[0];
            DIR_LEFT:  blocked = hit_q[1];
            DIR_RIGHT: blocked = hit_q[2];
          endcase
          if (!blocked) begin
            unique case (dir_q)
              DIR_UP:    velY_d = -speed_q;
              DIR_DOWN:  velY_d = speed_q;
              DIR_LEFT:  velX_d = -speed_q;
              DIR_RIGHT: velX_d = speed_q;
            endcase
          end
        end
        hit_d     = '0;
        dirLock_d = 1'b0;
        state_d   = APPLY;
      end
      APPLY: begin
        xPos_d   = clampPos(sumX, X_MIN, X_MAX);
        yPos_d   = clampPos(sumY, Y_MIN, Y_MAX);
        moving_d = (xPos_d != xPos_q) || (yPos_d != yPos_q);
        speed_d  = POS_W'(SPEED_TABLE[lvlSat]);
        curLvl_d = lvlSat;
        state_d  = COLLECT;
      end
    endcase

    // Respawn overrides whatever the FSM decided; the speed setting survives it
    if (respawn_i) begin
      state_d   = IDLE;
      xPos_d    = SPAWN_X;
      yPos_d    = SPAWN_Y;
      facing_d  = DIR_DOWN;
      moving_d  = 1'b0;
      dirLock_d = 1'b0;
      hit_d     = '0;
      velX_d    = '0;
      velY_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      facing_q  <= DIR_DOWN;
      dirLock_q <= 1'b0;
      hit_q     <= '0;
      xPos_q    <= SPAWN_X;
      yPos_q    <= SPAWN_Y;
      velX_q    <= '0;
      velY_q    <= '0;
      speed_q   <= SPEED0;
      curLvl_q  <= '0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      facing_q  <= facing_d;
      dirLock_q <= dirLock_d;
      hit_q     <= hit_d;
      xPos_q    <= xPos_d;
      yPos_q    <= yPos_d;
      velX_q    <= velX_d;
      velY_q    <= velY_d;
      speed_q   <= speed_d;
      curLvl_q  <= curLvl_d;
      moving_q  <= moving_d;
    end
  end

  assign topLeftX_o        = 11'(xPos_q >>> FP_SHIFT);
  assign topLeftY_o        = 11'(yPos_q >>> FP_SHIFT);
  assign facing_o          = facing_q;
  assign moving_o          = moving_q;
  assign cur_speed_level_o = curLvl_q;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Scoreboard bench for sprite_move_ctrl: a per-frame model pushes the expected
// outputs, each scenario task pops and compares once the frame has been applied.
module tb_sprite_move_ctrl;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic upKey = 1'b0, downKey = 1'b0, leftKey = 1'b0, rightKey = 1'b0;
  logic freeze = 1'b0, respawn = 1'b0, collision = 1'b0;
  logic [3:0] hitEdge = 4'd0;
  logic [1:0] speedLevel = 2'd0;
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0] facing;
  logic moving;
  logic [1:0] curLvl;

  always #5 clk = ~clk;

  sprite_move_ctrl dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame_i    (sof),
    .up_key_i          (upKey),
    .down_key_i        (downKey),
    .left_key_i        (leftKey),
    .right_key_i       (rightKey),
    .freeze_i          (freeze),
    .respawn_i         (respawn),
    .collision_i       (collision),
    .HitEdgeCode_i     (hitEdge),
    .speed_level_i     (speedLevel),
    .topLeftX_o        (topLeftX),
    .topLeftY_o        (topLeftY),
    .facing_o          (facing),
    .moving_o          (moving),
    .cur_speed_level_o (curLvl)
  );

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic [1:0]         face;
    logic               mov;
    logic [1:0]         lvl;
  } obs_t;

  localparam int X_LO = 960;
  localparam int X_HI = 37824;
  localparam int Y_LO = 3072;
  localparam int Y_HI = 27648;
  localparam logic [3:0] K_U = 4'b1000, K_D = 4'b0100, K_L = 4'b0010, K_R = 4'b0001;

  int speeds [4] = '{70, 105, 140, 175};
  obs_t sb[$];
  int checks = 0;
  int failures = 0;

  int mX, mY, mSpeed;
  logic [1:0] mFacing, mLvl;
  logic mMoving;

  function automatic obs_t modelObs();
    obs_t o;
    o.x = 11'(mX >>> 6);
    o.y = 11'(mY >>> 6);
    o.face = mFacing;
    o.mov = mMoving;
    o.lvl = mLvl;
    return o;
  endfunction

  function automatic obs_t sampleDut();
    obs_t o;
    o.x = topLeftX;
    o.y = topLeftY;
    o.face = facing;
    o.mov = moving;
    o.lvl = curLvl;
    return o;
  endfunction

  function automatic string fmtObs(obs_t o);
    return $sformatf("(x=%0d y=%0d face=%0d mov=%0d lvl=%0d)", o.x, o.y, o.face, o.mov, o.lvl);
  endfunction

  function automatic int clampI(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic setKeys(input logic [3:0] k);
    upKey = k[3];
    downKey = k[2];
    leftKey = k[1];
    rightKey = k[0];
  endtask

  // Model of one complete frame; the expected result goes onto the scoreboard
  task automatic predictFrame(input logic [3:0] kA, input logic [3:0] kB,
                              input logic [3:0] hit, input logic frz);
    logic [3:0] k;
    logic [1:0] d;
    logic blk;
    int vx, vy, nx, ny;
    vx = 0;
    vy = 0;
    k = frz ? 4'b0 : ((kA != 4'b0) ? kA : kB);
    if (k != 4'b0) begin
      d = k[3] ? 2'd0 : k[2] ? 2'd1 : k[1] ? 2'd2 : 2'd3;
      mFacing = d;
      case (d)
        2'd0: blk = hit[3];
        2'd1: blk = hit[0];
        2'd2: blk = hit[1];
        default: blk = hit[2];
      endcase
      if (!blk) begin
        case (d)
          2'd0: vy = -mSpeed;
          2'd1: vy = mSpeed;
          2'd2: vx = -mSpeed;
          default: vx = mSpeed;
        endcase
      end
    end
    nx = clampI(mX + vx, X_LO, X_HI);
    ny = clampI(mY + vy, Y_LO, Y_HI);
    mMoving = (nx != mX) || (ny != mY);
    mX = nx;
    mY = ny;
    mLvl = speedLevel;
    mSpeed = speeds[speedLevel];
    sb.push_back(modelObs());
  endtask

  // Drives one frame from inside COLLECT and returns at the cycle the new position is visible
  task automatic doFrame(input logic [3:0] kA, input logic [3:0] kB,
                         input logic [3:0] hit, input logic frz);
    predictFrame(kA, kB, hit, frz);
    @(negedge clk); freeze = frz; setKeys(kA);
    @(negedge clk); setKeys(kB);
    @(negedge clk); setKeys(4'b0); collision = (hit != 4'b0); hitEdge = hit;
    @(negedge clk); collision = 1'b0; hitEdge = 4'b0; sof = 1'b1;
    @(negedge clk); sof = 1'b0; freeze = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    mX = X_LO; mY = Y_LO; mFacing = 2'd1; mMoving = 1'b0; mSpeed = 70; mLvl = 2'd0;
    resetN = 1'b0;
    @(negedge clk);
    sb.push_back(modelObs());
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL reset_hold: got %s want %s", fmtObs(got), fmtObs(exp));
    end
    @(negedge clk); resetN = 1'b1;
    // Keys while still idle must not be captured
    setKeys(K_D);
    repeat (4) @(negedge clk);
    setKeys(4'b0);
    sb.push_back(modelObs());
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL reset_release: got %s want %s", fmtObs(got), fmtObs(exp));
    end
    sof = 1'b1;
    @(negedge clk); sof = 1'b0;
    doFrame(4'b0, 4'b0, 4'b0, 1'b0);
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL idle_first_frame: got %s want %s", fmtObs(got), fmtObs(exp));
    end
  endtask

  task automatic test_move_right();
    obs_t got, exp;
    logic signed [10:0] oldX;
    oldX = 11'(mX >>> 6);
    predictFrame(K_R, 4'b0, 4'b0, 1'b0);
    @(negedge clk); setKeys(K_R);
    repeat (3) @(negedge clk);
    setKeys(4'b0); sof = 1'b1;
    @(negedge clk); sof = 1'b0;
    checks++;
    if (topLeftX !== oldX) begin
      failures++;
      $display("[TB] FAIL latency_t1: got x=%0d want %0d", topLeftX, oldX);
    end
    @(negedge clk);
    checks++;
    if (topLeftX !== oldX) begin
      failures++;
      $display("[TB] FAIL latency_t2: got x=%0d want %0d", topLeftX, oldX);
    end
    @(negedge clk);
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL move_right: got %s want %s", fmtObs(got), fmtObs(exp));
    end
  endtask

  task automatic test_two_keys();
    obs_t got, exp;
    doFrame(K_D | K_L, K_L, 4'b0, 1'b0);
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL two_keys: got %s want %s", fmtObs(got), fmtObs(exp));
    end
  endtask

  task automatic test_collision();
    obs_t got, exp;
    doFrame(K_R, 4'b0, 4'b0100, 1'b0);
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL hit_blocks: got %s want %s", fmtObs(got), fmtObs(exp));
    end
    doFrame(K_R, 4'b0, 4'b1000, 1'b0);
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL hit_other_edge: got %s want %s", fmtObs(got), fmtObs(exp));
    end
  endtask

  task automatic test_edge_speed();
    obs_t got, exp;
    speedLevel = 2'd3;
    for (int i = 0; i < 300 && mX < X_HI; i++) begin
      doFrame(K_R, 4'b0, 4'b0, 1'b0);
      got = sampleDut(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL edge_run frame %0d: got %s want %s", i, fmtObs(got), fmtObs(exp));
      end
    end
    speedLevel = 2'd0;
    for (int i = 0; i < 2; i++) begin
      doFrame(K_R, 4'b0, 4'b0, 1'b0);
      got = sampleDut(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL edge_clamp %0d: got %s want %s", i, fmtObs(got), fmtObs(exp));
      end
    end
    speedLevel = 2'd2;
    for (int i = 0; i < 2; i++) begin
      doFrame(K_L, 4'b0, 4'b0, 1'b0);
      got = sampleDut(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL speed_change %0d: got %s want %s", i, fmtObs(got), fmtObs(exp));
      end
    end
  endtask

  task automatic test_respawn_freeze();
    obs_t got, exp;
    for (int i = 0; i < 10; i++) begin
      doFrame((i % 2 == 0) ? K_D : K_R, 4'b0, 4'b0, 1'b0);
      got = sampleDut(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL pre_respawn %0d: got %s want %s", i, fmtObs(got), fmtObs(exp));
      end
    end
    // A direction captured just before respawn must be forgotten
    @(negedge clk); setKeys(K_R);
    @(negedge clk); setKeys(4'b0); respawn = 1'b1;
    @(negedge clk); respawn = 1'b0;
    mX = X_LO; mY = Y_LO; mFacing = 2'd1; mMoving = 1'b0;
    sb.push_back(modelObs());
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL respawn: got %s want %s", fmtObs(got), fmtObs(exp));
    end
    setKeys(K_D);
    repeat (3) @(negedge clk);
    setKeys(4'b0); sof = 1'b1;
    @(negedge clk); sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.push_back(modelObs());
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL respawn_idle: got %s want %s", fmtObs(got), fmtObs(exp));
    end
    doFrame(K_U, K_U, 4'b0, 1'b1);
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL freeze: got %s want %s", fmtObs(got), fmtObs(exp));
    end
    doFrame(K_D, 4'b0, 4'b0, 1'b0);
    got = sampleDut(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL speed_kept: got %s want %s", fmtObs(got), fmtObs(exp));
    end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_two_keys();
    test_collision();
    test_edge_speed();
    test_respawn_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not end, %0d checks done", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
